light_mode_scheduler: RTL and testbench
=======================================

Name: light_mode_scheduler

Overview:
- Top-level sequencer choosing which traffic controller owns the lights: timed mode (day) or sensor mode (2100–0600).
- Produces the enable_sensor_mode / enable_timed_mode gates and an all-red interval at every handoff.
- Debounces the raw vehicle sensor and issues the one-cycle SET_srl request into sensor mode.
- Sits between the time-of-day counter and the two mode controllers.

Parameters:
- NIGHT_START, 21, first hour (inclusive) of sensor mode
- NIGHT_END, 6, first hour (inclusive) of timed mode
- ALLRED_CYCLES, 3, cycles of forced all-red at power-up and at each handoff (≥1)
- DEBOUNCE, 4, consecutive synchronized-high cycles required to qualify a sensor trip (≥1)

Ports:
- CLOCK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- HOUR  input  5  current hour, 0–23
- sensor_trip  input  1  raw, asynchronous vehicle sensor
- timed_safe  input  1  timed controller is at a safe handoff point
- sensor_safe  input  1  sensor controller is idle at a safe handoff point
- enable_timed_mode  output  1  gate for the timed controller
- enable_sensor_mode  output  1  gate for the sensor controller
- all_red  output  1  force all approaches red
- SET_srl  output  1  one-cycle qualified vehicle request to the sensor-mode latch
- mode_state  output  3  current FSM state encoding, for debug

Behaviour:
- night = (HOUR >= NIGHT_START) | (HOUR < NIGHT_END).
- HOUR values 24–31 are invalid; night holds its last valid value, which is 0 out of reset.
- FSM states, with the mode_state encoding:
  - INIT=0, TIMED=1, DRAIN_T=2, SENSOR=3, DRAIN_S=4, RED_TS=5, RED_ST=6.
  - Code 7 is unreachable; if entered, the next state is INIT.
- Transitions, evaluated on each rising CLOCK edge:
  - INIT: hold ALLRED_CYCLES cycles, then go to SENSOR if night, else TIMED.
  - TIMED: if night, go to DRAIN_T.
  - DRAIN_T: if !night, go back to TIMED. This abort wins over timed_safe in the same cycle. Else if timed_safe, go to RED_TS.
  - RED_TS: hold ALLRED_CYCLES cycles, then go to SENSOR unconditionally.
  - SENSOR: if !night, go to DRAIN_S.
  - DRAIN_S: if night, go back to SENSOR. This abort wins over sensor_safe. Else if sensor_safe, go to RED_ST.
  - RED_ST: hold ALLRED_CYCLES cycles, then go to TIMED unconditionally.
- All-red timer:
  - Cleared on entry to INIT, RED_TS or RED_ST; increments each cycle while in those states.
  - The exit edge is the one on which timer == ALLRED_CYCLES-1, so each red state lasts exactly ALLRED_CYCLES cycles.
- Outputs are decoded from the state register (Moore):
  - enable_timed_mode = TIMED | DRAIN_T.
  - enable_sensor_mode = SENSOR | DRAIN_S.
  - all_red = INIT | RED_TS | RED_ST.
  - The two enables are never high together, and neither is high while all_red is high.
- Sensor path:
  - Two-flop synchronizer (sync1 → sync2).
  - Debounce counter: increments on edges where sync2 is high, saturating at DEBOUNCE; clears to 0 on any edge where sync2 is low.
  - SET_srl is registered and goes high for exactly one cycle on the edge where the counter goes from DEBOUNCE-1 to DEBOUNCE, provided the state is SENSOR on that edge.
  - In any other state the qualification is dropped, not deferred.
  - A held sensor produces only one pulse; re-arming requires sync2 low for at least one edge.
- Latency: if sensor_trip is first sampled high at edge 0, SET_srl is high in the cycle after edge 1+DEBOUNCE (edge 5 for the default DEBOUNCE=4).
- Reset values (RESET low, applied immediately and asynchronously, including mid-handoff):
  - state=INIT, all_red=1, both enables=0, SET_srl=0.
  - Timers, synchronizer and debounce counter = 0; night register = 0.

Test Plan:
- Reset release with HOUR=12: all_red=1 for 3 cycles, then enable_timed_mode=1, mode_state=1. Repeat with HOUR=22: SENSOR after 3 cycles, enable_sensor_mode=1.
- Day→night handoff: in TIMED, HOUR=21 → DRAIN_T with enable_timed_mode still 1. timed_safe pulse → RED_TS with all_red=1 and both enables 0 for exactly 3 cycles → SENSOR.
- Aborted handoffs:
  - In DRAIN_T, set HOUR=20 and timed_safe=1 in the same cycle → next state TIMED, never RED_TS.
  - Same check for DRAIN_S with HOUR=22.
- Debounce, in SENSOR:
  - sensor_trip high for 3 cycles then low → no SET_srl.
  - sensor_trip held high 20 cycles → exactly one SET_srl pulse, 5 edges after the first sample.
  - Drop low 1 cycle and raise again → a second pulse.
- Pulse suppression: in TIMED, a held sensor_trip gives no SET_srl. HOUR=6 while in SENSOR with a trip in progress → no pulse once the state reaches DRAIN_S.
- Async reset mid-RED_ST: drive RESET low between edges → outputs reach reset values without waiting for a clock edge; HOUR=25 after reset holds the last valid night value.

Source files
------------

// File: rtl/light_mode_scheduler_if.sv
// Signal bundle between the time-of-day/controller side and the light mode scheduler.
interface light_mode_scheduler_if;
    logic [4:0] HOUR;
    logic       sensor_trip;
    logic       timed_safe;
    logic       sensor_safe;
    logic       enable_timed_mode;
    logic       enable_sensor_mode;
    logic       all_red;
    logic       SET_srl;
    logic [2:0] mode_state;

    modport master (
        output HOUR, sensor_trip, timed_safe, sensor_safe,
        input  enable_timed_mode, enable_sensor_mode, all_red, SET_srl, mode_state
    );

    modport slave (
        input  HOUR, sensor_trip, timed_safe, sensor_safe,
        output enable_timed_mode, enable_sensor_mode, all_red, SET_srl, mode_state
    );
endinterface

// File: rtl/light_mode_scheduler.sv
// Chooses timed (day) or sensor (night) traffic mode, inserts all-red at every
// handoff, and debounces the vehicle sensor into a one-cycle SET_srl request.
module light_mode_scheduler #(
    parameter int unsigned NIGHT_START   = 21,
    parameter int unsigned NIGHT_END     = 6,
    parameter int unsigned ALLRED_CYCLES = 3,
    parameter int unsigned DEBOUNCE      = 4
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    light_mode_scheduler_if.slave  bus
);

    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned TIMER_W = (ALLRED_CYCLES < 2) ? 1 : $clog2(ALLRED_CYCLES);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);

    localparam logic [2:0] INIT    = 3'd0;
    localparam logic [2:0] TIMED   = 3'd1;
    localparam logic [2:0] DRAIN_T = 3'd2;
    localparam logic [2:0] SENSOR  = 3'd3;
    localparam logic [2:0] DRAIN_S = 3'd4;
    localparam logic [2:0] RED_TS  = 3'd5;
    localparam logic [2:0] RED_ST  = 3'd6;

    logic [2:0]         state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               night, night_c, hour_valid_c, red_c, timer_done_c;
    logic               sync1, sync2;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               set_next;
    logic               enable_timed, enable_sensor, all_red, set_srl;

    // Out-of-range hours keep the last valid day/night decision.
    assign hour_valid_c = bus.HOUR < HOUR_W'(24);
    assign night_c      = hour_valid_c
                        ? ((bus.HOUR >= HOUR_W'(NIGHT_START)) | (bus.HOUR < HOUR_W'(NIGHT_END)))
                        : night;

    assign red_c        = (state == INIT) | (state == RED_TS) | (state == RED_ST);
    assign timer_done_c = timer == TIMER_W'(ALLRED_CYCLES - 1);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= INIT;
            timer <= '0;
            night <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            night <= night_c;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = '0;
        case (state)
            INIT:    if (timer_done_c) state_next = night_c ? SENSOR : TIMED;
            TIMED:   if (night_c) state_next = DRAIN_T;
            DRAIN_T: begin
                if (!night_c)           state_next = TIMED;
                else if (bus.timed_safe) state_next = RED_TS;
            end
            RED_TS:  if (timer_done_c) state_next = SENSOR;
            SENSOR:  if (!night_c) state_next = DRAIN_S;
            DRAIN_S: begin
                if (night_c)              state_next = SENSOR;
                else if (bus.sensor_safe) state_next = RED_ST;
            end
            RED_ST:  if (timer_done_c) state_next = TIMED;
            default: state_next = INIT;
        endcase
        // Timer runs only while staying in a red state; any entry starts from zero.
        if (red_c && (state_next == state)) timer_next = TIMER_W'(timer + 1'b1);
    end

    // Sensor synchronizer and saturating debounce counter.
    always_comb begin
        cnt_next = '0;
        if (sync2) cnt_next = (cnt == CNT_W'(DEBOUNCE)) ? cnt : CNT_W'(cnt + 1'b1);
        set_next = sync2 && (cnt == CNT_W'(DEBOUNCE - 1)) && (state == SENSOR);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            set_srl <= 1'b0;
        end else begin
            sync1   <= bus.sensor_trip;
            sync2   <= sync1;
            cnt     <= cnt_next;
            set_srl <= set_next;
        end
    end

    // Mode gates track the state register; registered from its next value so they align with it.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            enable_timed  <= 1'b0;
            enable_sensor <= 1'b0;
            all_red       <= 1'b1;
        end else begin
            enable_timed  <= (state_next == TIMED)  | (state_next == DRAIN_T);
            enable_sensor <= (state_next == SENSOR) | (state_next == DRAIN_S);
            all_red       <= (state_next == INIT) | (state_next == RED_TS) | (state_next == RED_ST)
                           | (state_next == 3'd7);
        end
    end

    assign bus.enable_timed_mode  = enable_timed;
    assign bus.enable_sensor_mode = enable_sensor;
    assign bus.all_red            = all_red;
    assign bus.SET_srl            = set_srl;
    assign bus.mode_state         = state;

endmodule

// File: tb/tb_light_mode_scheduler.sv
// Directed bench for light_mode_scheduler: mode handoffs, aborts, debounce and async reset.
module tb_light_mode_scheduler;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   excl_viol = 0;
    int   pulses, first;

    light_mode_scheduler_if bus();

    light_mode_scheduler dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    // Enables must never overlap each other or all_red.
    always @(negedge CLOCK) begin
        if (RESET && ((bus.enable_timed_mode && bus.enable_sensor_mode) ||
                      (bus.all_red && (bus.enable_timed_mode || bus.enable_sensor_mode))))
            excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic count_pulses(input int n, output int np, output int fk);
        np = 0;
        fk = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge CLOCK);
            if (bus.SET_srl) begin
                np++;
                if (fk == 0) fk = k;
            end
        end
    endtask

    task automatic check_mode(input string tag, input logic [2:0] m,
                              input logic et, input logic es, input logic ar);
        check({tag, ".mode"}, 32'(bus.mode_state), 32'(m));
        check({tag, ".en_t"}, 32'(bus.enable_timed_mode), 32'(et));
        check({tag, ".en_s"}, 32'(bus.enable_sensor_mode), 32'(es));
        check({tag, ".red"},  32'(bus.all_red), 32'(ar));
    endtask

    initial begin
        bus.HOUR        = 5'd12;
        bus.sensor_trip = 1'b0;
        bus.timed_safe  = 1'b0;
        bus.sensor_safe = 1'b0;

        // Reset values, then release with HOUR=12
        step(1);
        check_mode("rst", 3'd0, 1'b0, 1'b0, 1'b1);
        check("rst.set", 32'(bus.SET_srl), 32'd0);
        RESET = 1'b1;
        step(2);
        check_mode("init12", 3'd0, 1'b0, 1'b0, 1'b1);
        step(1);
        check_mode("timed", 3'd1, 1'b1, 1'b0, 1'b0);

        // Held sensor in TIMED gives no pulse
        bus.sensor_trip = 1'b1;
        count_pulses(12, pulses, first);
        check("timed_nopulse", 32'(pulses), 32'd0);
        bus.sensor_trip = 1'b0;
        step(3);

        // Day -> night handoff
        bus.HOUR = 5'd21;
        step(1);
        check_mode("drain_t", 3'd2, 1'b1, 1'b0, 1'b0);
        step(2);
        check("drain_t_hold", 32'(bus.mode_state), 32'd2);
        bus.timed_safe = 1'b1;
        step(1);
        bus.timed_safe = 1'b0;
        check_mode("red_ts1", 3'd5, 1'b0, 1'b0, 1'b1);
        step(2);
        check_mode("red_ts3", 3'd5, 1'b0, 1'b0, 1'b1);
        step(1);
        check_mode("sensor", 3'd3, 1'b0, 1'b1, 1'b0);

        // Short trip (3 cycles) does not qualify
        bus.sensor_trip = 1'b1;
        step(3);
        bus.sensor_trip = 1'b0;
        count_pulses(10, pulses, first);
        check("short_trip", 32'(pulses), 32'd0);

        // Held trip: one pulse, visible after edge 5 (6th negedge)
        bus.sensor_trip = 1'b1;
        count_pulses(20, pulses, first);
        check("held_count", 32'(pulses), 32'd1);
        check("held_latency", 32'(first), 32'd6);

        // One low cycle re-arms
        bus.sensor_trip = 1'b0;
        step(1);
        bus.sensor_trip = 1'b1;
        count_pulses(20, pulses, first);
        check("rearm_count", 32'(pulses), 32'd1);
        bus.sensor_trip = 1'b0;
        step(4);

        // Aborted night -> day handoff
        bus.HOUR = 5'd12;
        step(1);
        check_mode("drain_s", 3'd4, 1'b0, 1'b1, 1'b0);
        bus.HOUR = 5'd22;
        bus.sensor_safe = 1'b1;
        step(1);
        bus.sensor_safe = 1'b0;
        check_mode("abort_s", 3'd3, 1'b0, 1'b1, 1'b0);

        // Trip in progress when day arrives: qualification dropped
        bus.sensor_trip = 1'b1;
        step(2);
        bus.HOUR = 5'd6;
        count_pulses(10, pulses, first);
        check("drop_pulses", 32'(pulses), 32'd0);
        check("drop_state", 32'(bus.mode_state), 32'd4);
        bus.sensor_trip = 1'b0;
        step(3);

        // Into RED_ST, then async reset between edges
        bus.sensor_safe = 1'b1;
        step(1);
        bus.sensor_safe = 1'b0;
        check_mode("red_st", 3'd6, 1'b0, 1'b0, 1'b1);
        step(1);
        #2;
        RESET = 1'b0;
        bus.HOUR = 5'd25;
        #1;
        check_mode("async_rst", 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge CLOCK);
        RESET = 1'b1;
        step(2);
        check("init25", 32'(bus.mode_state), 32'd0);
        step(1);
        check_mode("timed25", 3'd1, 1'b1, 1'b0, 1'b0);

        // Invalid hour holds last valid night=1
        bus.HOUR = 5'd22;
        step(1);
        bus.HOUR = 5'd27;
        step(2);
        check("hold_night", 32'(bus.mode_state), 32'd2);

        // Aborted day -> night handoff: abort beats timed_safe
        bus.HOUR = 5'd20;
        bus.timed_safe = 1'b1;
        step(1);
        bus.timed_safe = 1'b0;
        check_mode("abort_t", 3'd1, 1'b1, 1'b0, 1'b0);

        // Reset release at night goes straight to SENSOR
        bus.HOUR = 5'd22;
        RESET = 1'b0;
        step(1);
        RESET = 1'b1;
        step(2);
        check("init22", 32'(bus.mode_state), 32'd0);
        step(1);
        check_mode("sensor22", 3'd3, 1'b0, 1'b1, 1'b0);

        check("exclusive", 32'(excl_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
